// File: rtl/sc_pkg.sv
// Shared slow-control definitions: frame length, MAROC frame field map and checker FSM states.
package sc_pkg;

  localparam int unsigned FRAME_W = 829;

  // Bit offsets of the MAROC slow-control frame fields, in transmit order.
  localparam int unsigned OFS_ON_OFF_OTABG      = 0;
  localparam int unsigned OFS_ON_OFF_DAC        = 1;
  localparam int unsigned OFS_SMALL_DAC         = 2;
  localparam int unsigned OFS_DAC2_LSB          = 3;
  localparam int unsigned OFS_DAC2_MSB          = 12;
  localparam int unsigned OFS_DAC1_LSB          = 13;
  localparam int unsigned OFS_DAC1_MSB          = 22;
  localparam int unsigned OFS_ENB_OUTADC        = 23;
  localparam int unsigned OFS_INV_STARTCMPTGRAY = 24;
  localparam int unsigned OFS_RAMP_8BIT         = 25;
  localparam int unsigned OFS_RAMP_10BIT        = 26;
  localparam int unsigned OFS_MASK_OR_LSB       = 27;
  localparam int unsigned OFS_MASK_OR_MSB       = 154;
  localparam int unsigned OFS_GLOBAL_LSB        = 155;
  localparam int unsigned OFS_GLOBAL_MSB        = 188;
  localparam int unsigned OFS_GAIN_LSB          = 189;
  localparam int unsigned OFS_GAIN_MSB          = 764;
  localparam int unsigned OFS_CTEST_LSB         = 765;
  localparam int unsigned OFS_CTEST_MSB         = 828;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sc_gap_timer.sv
// Gap counter with synchronous clear and enable; term_c flags the terminal count and the
// counter holds there until cleared.
module sc_gap_timer #(
  parameter int unsigned TERMINAL = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  localparam int unsigned CW = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !term_c) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term_c = (cnt == CW'(TERMINAL));

endmodule

// File: rtl/sc_readback_checker.sv
// Compares the MAROC Q_SC readback against the previously loaded slow-control frame.
// Optional readback capture register built when SC_RB_CAPTURE_EN is defined.
module sc_readback_checker #(
  parameter int unsigned FRAME_W        = sc_pkg::FRAME_W,
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               CK_in,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] exp_frame,
  input  logic               bit_valid,
  input  logic               Q_SC,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic [FRAME_W-1:0] cap_frame
);

  import sc_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  logic [1:0]         state, state_d;
  logic [FRAME_W-1:0] exp_sr, exp_sr_d;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0]   err_count_d, first_err_idx_d;
  logic               busy_d, done_d, pass_d, timeout_d;
  logic               gap_term_c;
  logic               gap_clr_c;

  // Gap timer only runs while a check is in progress; any strobe or restart clears it.
  assign gap_clr_c = start || bit_valid || (state != ST_RUN);

  sc_gap_timer #(
    .TERMINAL(TIMEOUT_CYCLES - 1)
  ) u_gap_timer (
    .clk    (CK_in),
    .rst    (rst),
    .clr    (gap_clr_c),
    .en     (1'b1),
    .term_c (gap_term_c)
  );

  // Next-state and next-output logic; the expected frame shifts right so bit 0 is always next.
  always_comb begin
    state_d         = state;
    exp_sr_d        = exp_sr;
    bit_cnt_d       = bit_cnt;
    err_count_d     = err_count;
    first_err_idx_d = first_err_idx;
    pass_d          = pass;
    timeout_d       = timeout;
    done_d          = 1'b0;

    if (start) begin
      state_d         = ST_RUN;
      exp_sr_d        = exp_frame;
      bit_cnt_d       = '0;
      err_count_d     = '0;
      first_err_idx_d = '1;
      pass_d          = 1'b0;
      timeout_d       = 1'b0;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (bit_valid) begin
            exp_sr_d  = exp_sr >> 1;
            bit_cnt_d = bit_cnt + CNT_W'(1);
            if (Q_SC != exp_sr[0]) begin
              if (err_count == '0) begin
                first_err_idx_d = bit_cnt;
              end
              if (err_count != ERR_MAX) begin
                err_count_d = err_count + CNT_W'(1);
              end
            end
            if (bit_cnt == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = (err_count_d == '0);
            end
          end else if (gap_term_c) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CK_in) begin
    if (rst) begin
      state         <= ST_IDLE;
      exp_sr        <= '0;
      bit_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else begin
      state         <= state_d;
      exp_sr        <= exp_sr_d;
      bit_cnt       <= bit_cnt_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= timeout_d;
      err_count     <= err_count_d;
      first_err_idx <= first_err_idx_d;
    end
  end

`ifdef SC_RB_CAPTURE_EN
  logic [FRAME_W-1:0] cap_q;

  // New readback bit enters the MSB so a full frame lands with bit 0 at the LSB.
  always_ff @(posedge CK_in) begin
    if (rst || start) begin
      cap_q <= '0;
    end else if ((state == ST_RUN) && bit_valid) begin
      cap_q <= {Q_SC, cap_q[FRAME_W-1:1]};
    end
  end

  assign cap_frame = cap_q;
`else
  assign cap_frame = '0;
`endif

endmodule

// File: tb/tb_sc_readback_checker.sv
// Directed/randomized bench for sc_readback_checker with a frame-level reference model.
module tb_sc_readback_checker;

  localparam int unsigned FW = 829;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 4096;

  logic          CK_in = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] exp_frame;
  logic          bit_valid;
  logic          Q_SC;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic [FW-1:0] cap_frame;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  sc_readback_checker #(
    .FRAME_W(FW),
    .CNT_W(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CK_in         (CK_in),
    .rst           (rst),
    .start         (start),
    .exp_frame     (exp_frame),
    .bit_valid     (bit_valid),
    .Q_SC          (Q_SC),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .cap_frame     (cap_frame)
  );

  always #5 CK_in = ~CK_in;

  always @(negedge CK_in) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge CK_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: result of a check over the first n readback bits.
  function automatic int ref_errs(input logic [FW-1:0] e, input logic [FW-1:0] r, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (e[i] != r[i]) c++;
    return c;
  endfunction

  function automatic int ref_first(input logic [FW-1:0] e, input logic [FW-1:0] r, input int n);
    for (int i = 0; i < n; i++) if (e[i] != r[i]) return i;
    return (1 << CW) - 1;
  endfunction

  function automatic logic [FW-1:0] ref_cap(input logic [FW-1:0] r, input int n);
    logic [FW-1:0] c = '0;
`ifdef SC_RB_CAPTURE_EN
    for (int i = 0; i < n; i++) c[FW - n + i] = r[i];
`endif
    return c;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic start_check(input logic [FW-1:0] e, input logic bv, input logic q);
    start = 1'b1;
    exp_frame = e;
    bit_valid = bv;
    Q_SC = q;
    step();
    start = 1'b0;
    bit_valid = 1'b0;
  endtask

  // Strobes bits [from, to) of r; gap < 0 picks 0..3 idle cycles before each non-first bit.
  task automatic send_bits(input logic [FW-1:0] r, input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      if (i != from) repeat ((gap < 0) ? $urandom_range(0, 3) : gap) step();
      bit_valid = 1'b1;
      Q_SC = r[i];
      step();
      bit_valid = 1'b0;
    end
  endtask

  task automatic check_results(input string t, input logic [FW-1:0] e, input logic [FW-1:0] r,
                               input int n, input logic timed);
    int ne = ref_errs(e, r, n);
    chk({t, "_err_count"}, 32'(err_count), 32'(ne));
    chk({t, "_first_err_idx"}, 32'(first_err_idx), 32'(ref_first(e, r, n)));
    chk({t, "_pass"}, 32'(pass), 32'((ne == 0) && !timed && (n == FW)));
    chk({t, "_timeout"}, 32'(timeout), 32'(timed));
    chk_frame({t, "_cap_frame"}, cap_frame, ref_cap(r, n));
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_busy"}, 32'(busy), 32'(0));
    chk({t, "_done"}, 32'(done), 32'(0));
    chk({t, "_pass"}, 32'(pass), 32'(0));
    chk({t, "_timeout"}, 32'(timeout), 32'(0));
    chk({t, "_err_count"}, 32'(err_count), 32'(0));
    chk({t, "_first_err_idx"}, 32'(first_err_idx), 32'(10'h3FF));
    chk_frame({t, "_cap_frame"}, cap_frame, '0);
  endtask

  initial begin
    logic [FW-1:0] e;
    logic [FW-1:0] r;
    int d0;

    rst = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    Q_SC = 1'b0;
    exp_frame = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // Clean readback, alternating pattern, one strobe every two cycles.
    for (int i = 0; i < FW; i++) e[i] = (i % 2 == 0);
    d0 = done_cnt;
    start_check(e, 1'b0, 1'b0);
    chk("clean_busy", 32'(busy), 32'(1));
    send_bits(e, 0, FW - 1, 1);
    chk("clean_no_early_done", 32'(done), 32'(0));
    step();
    send_bits(e, FW - 1, FW, 1);
    chk("clean_done", 32'(done), 32'(1));
    chk("clean_busy_low", 32'(busy), 32'(0));
    check_results("clean", e, e, FW, 1'b0);
    step();
    chk("clean_done_pulse", 32'(done), 32'(0));
    chk("clean_pass_held", 32'(pass), 32'(1));
    step();
    chk("clean_done_count", 32'(done_cnt - d0), 32'(1));

    // Injected errors at bits 3, 400 and 828.
    e = rand_frame();
    r = e;
    r[3] = ~r[3];
    r[400] = ~r[400];
    r[828] = ~r[828];
    start_check(e, 1'b0, 1'b0);
    send_bits(r, 0, FW, -1);
    chk("inject_done", 32'(done), 32'(1));
    check_results("inject", e, r, FW, 1'b0);
    chk("inject_err_const", 32'(err_count), 32'(3));

    // Strobes stop after bits 0..99: timeout after TO idle cycles.
    e = rand_frame();
    r = rand_frame();
    start_check(e, 1'b0, 1'b0);
    send_bits(r, 0, 100, -1);
    repeat (TO - 1) step();
    chk("timeout_not_yet", 32'(done), 32'(0));
    chk("timeout_busy", 32'(busy), 32'(1));
    step();
    chk("timeout_done", 32'(done), 32'(1));
    check_results("timeout", e, r, 100, 1'b1);

    // Restart at bit 500 with an all-zero frame.
    e = rand_frame();
    r = rand_frame();
    start_check(e, 1'b0, 1'b0);
    send_bits(r, 0, 500, -1);
    d0 = done_cnt;
    start_check('0, 1'b0, 1'b0);
    chk("restart_busy", 32'(busy), 32'(1));
    chk("restart_err_cleared", 32'(err_count), 32'(0));
    chk("restart_first_cleared", 32'(first_err_idx), 32'(10'h3FF));
    send_bits('0, 0, FW, -1);
    chk("restart_done", 32'(done), 32'(1));
    check_results("restart", '0, '0, FW, 1'b0);
    step();
    step();
    chk("restart_one_done", 32'(done_cnt - d0), 32'(1));

    // Strobes while idle are ignored.
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      bit_valid = 1'b1;
      Q_SC = 1'($urandom_range(0, 1));
      step();
      bit_valid = 1'b0;
      step();
    end
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_no_done", 32'(done_cnt - d0), 32'(0));
    chk("idle_err_count", 32'(err_count), 32'(0));
    chk("idle_pass_held", 32'(pass), 32'(1));

    // Start coincident with a (mismatching) strobe: that strobe is not counted.
    e = rand_frame();
    start_check(e, 1'b1, ~e[0]);
    send_bits(e, 0, FW - 1, -1);
    chk("coinc_no_early_done", 32'(done), 32'(0));
    chk("coinc_busy", 32'(busy), 32'(1));
    send_bits(e, FW - 1, FW, 0);
    chk("coinc_done", 32'(done), 32'(1));
    check_results("coinc", e, e, FW, 1'b0);

    // Reset in the middle of a check.
    e = rand_frame();
    r = rand_frame();
    start_check(e, 1'b0, 1'b0);
    send_bits(r, 0, 200, -1);
    chk("rstmid_busy", 32'(busy), 32'(1));
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rstmid");
    repeat (5) step();
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_readback_checker.md
Name: sc_readback_checker

Overview:
- Sits downstream of the slow-control transmitter. It consumes the MAROC shift-register readback output (Q_SC) while the next frame is shifted in.
- Compares the readback bit-by-bit against the previously loaded 829-bit frame. Reports pass/fail, error count, first failing bit index and a strobe-gap timeout.
- The host uses the result to confirm that the slow-control configuration actually landed in the ASIC.

Parameters:
- FRAME_W, 829, slow-control frame length in bits.
- CNT_W, 10, width of the bit counter and index outputs; must satisfy 2^CNT_W > FRAME_W.
- TIMEOUT_CYCLES, 4096, maximum CK_in cycles allowed between consecutive bit_valid strobes while running.

Ports:
- CK_in  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches exp_frame and arms a new check.
- exp_frame  in  FRAME_W  expected frame in transmit bit order: bit 0 is shifted first.
- bit_valid  in  1  one-cycle strobe per shifted bit, aligned to the transmitter's CK_SC rising edge.
- Q_SC  in  1  readback serial data; sampled only when bit_valid=1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a check (normal or timeout).
- pass  out  1  held result: 1 iff the last check completed with zero errors and no timeout.
- timeout  out  1  held: the last check aborted on a strobe gap.
- err_count  out  CNT_W  held number of mismatching bits in the last check.
- first_err_idx  out  CNT_W  held index of the first mismatching bit; all-ones if none.
- cap_frame  out  FRAME_W  captured readback frame (see Optional Feature).

Behaviour:
- Reset: state=IDLE. All outputs 0, except first_err_idx = all-ones. Internal bit counter, error counter and gap counter = 0.
- IDLE:
  - start=1 → load exp_frame into an internal shift register, clear the counters, go to RUN.
  - bit_valid is ignored in IDLE.
- RUN:
  - On each bit_valid, compare Q_SC against expected bit[bit_cnt].
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch, first_err_idx is set to bit_cnt.
  - bit_cnt increments on every bit_valid.
  - The gap counter clears on bit_valid and increments otherwise.
- RUN → DONE on either condition:
  - bit_valid with bit_cnt == FRAME_W-1.
  - Gap counter reaching TIMEOUT_CYCLES-1 without bit_valid; this sets timeout=1.
- DONE: lasts one cycle.
  - done=1; pass = (err_count==0 && !timeout).
  - Then return to IDLE.
  - Result outputs hold until the next start.
- Latency: done rises exactly one cycle after the cycle that samples the FRAME_W-th bit.
- start and bit_valid in the same cycle: start wins. That strobe is not counted; the first counted bit is the next strobe.
- start during RUN or DONE: abort the current check without asserting done, reload exp_frame, restart RUN. The held outputs are cleared to their reset values.
- Extra bit_valid strobes after DONE/IDLE are ignored.
- rst mid-check: immediate return to the reset state; no done pulse.
- Results reflect only the bits received; a timed-out check reports errors seen so far.

Optional Feature:
- Macro SC_RB_CAPTURE_EN.
- Defined: Q_SC is shifted into a FRAME_W capture register on each bit_valid in RUN. The new bit enters the MSB and the register shifts right, so after a full frame cap_frame[i] equals readback bit i. The register is cleared on start and on rst.
- Undefined: cap_frame is tied to 0 and no capture register is built (saves ~829 flops). Compare results are unchanged.

Decomposition:
- Shared package sc_pkg:
  - FRAME_W.
  - Field offset constants matching the frame map:
    - ON_OFF_otabg 0; ON_OFF_dac 1; small_dac 2.
    - DAC2 3..12; DAC1 13..22.
    - enb_outADC 23; inv_startCmptGray 24; ramp_8bit 25; ramp_10bit 26.
    - mask_OR 27..154.
    - global config 155..188.
    - GAIN 189..764.
    - Ctest 765..828.
  - State enum: IDLE, RUN, DONE.
- One natural sub-module, sc_gap_timer: a gap counter with clear/enable and a terminal flag, reusable by the transmitter's watchdog.

Test Plan:
- Clean readback: exp_frame=alternating 1010…, feed 829 matching bits at 1 strobe per 2 cycles → done one cycle after bit 828; pass=1, err_count=0, first_err_idx=1023; cap_frame==exp_frame when the macro is defined.
- Injected errors: flip bits 3, 400 and 828 → pass=0, err_count=3, first_err_idx=3.
- Timeout: stop strobes after bit 100 → done after TIMEOUT_CYCLES idle cycles; timeout=1, pass=0, err_count reflects bits 0..99 only.
- Restart: assert start again at bit 500 with a new frame of all zeros, then feed 829 zeros → exactly one done pulse; pass=1.
- Coincidence and reset: start coincident with bit_valid → that bit is not counted (829 further strobes are needed). rst at bit 200 → busy=0, no done, outputs at reset values.
- Strobe-free idle: 100 bit_valid pulses in IDLE → no state change, counters stay 0.
